// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer: shifts a config word into the PLL serial port, pulses reset, qualifies LOCK and supervises loss of lock.
// Optional `define PLL_RELOCK_EN: a lock loss retries from RESET with the latched config instead of entering FAIL.
module pll_cfg_sequencer #(
  parameter int CFG_W        = 27,
  parameter int SCLK_DIV     = 4,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_FILTER  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [7:0]       dly_in,
  input  logic             pll_lock,
  output logic             pll_reset_n,
  output logic             pll_bypass,
  output logic             pll_sclk,
  output logic             pll_sdi,
  output logic             pll_latch,
  output logic [7:0]       pll_dyndelay,
  output logic             busy,
  output logic             locked,
  output logic             timeout_err,
  output logic [7:0]       loss_cnt
);
  localparam int CNT_MAX = (2 * SCLK_DIV > RST_HOLD) ? 2 * SCLK_DIV : RST_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int FW      = $clog2(LOCK_FILTER + 1);
  localparam int TW      = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, RESET, WAIT_LOCK, LOCKED, FAIL} state_t;

  state_t           state, state_d;
  logic [1:0]       sync;
  logic             lock_s;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IW-1:0]    idx, idx_d;
  logic [FW-1:0]    filt, filt_d;
  logic [TW-1:0]    tcnt, tcnt_d;
  logic [CFG_W-1:0] cfg_q;
  logic [7:0]       dly_q, loss_q, loss_d;
  logic             tmo_q, tmo_d;
  logic             accept, bit_end, lock_hit, loss_hit, tmo_hit;
  logic             reset_n_d, bypass_d, sclk_d, sdi_d, latch_d, busy_d, locked_d;

  assign lock_s   = sync[1];
  assign accept   = start && (state == IDLE || state == LOCKED || state == FAIL);
  assign bit_end  = cnt == CW'(2 * SCLK_DIV - 1);
  assign lock_hit = lock_s && filt == FW'(LOCK_FILTER - 1);
  assign loss_hit = !lock_s && filt == FW'(LOCK_FILTER - 1);
  assign tmo_hit  = tcnt == TW'(LOCK_TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], pll_lock};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      filt   <= '0;
      tcnt   <= '0;
      cfg_q  <= '0;
      dly_q  <= '0;
      tmo_q  <= 1'b0;
      loss_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      filt   <= filt_d;
      tcnt   <= tcnt_d;
      tmo_q  <= tmo_d;
      loss_q <= loss_d;
      if (accept) begin
        cfg_q <= cfg_word;
        dly_q <= dly_in;
      end
    end
  end

  // start has priority over a simultaneous loss event in LOCKED; lock beats timeout in WAIT_LOCK
  always_comb begin
    state_d = state;
    case (state)
      IDLE, FAIL: state_d = start ? SHIFT : state;
      SHIFT:      state_d = (bit_end && idx == '0) ? LATCH : SHIFT;
      LATCH:      state_d = (cnt == CW'(SCLK_DIV - 1)) ? RESET : LATCH;
      RESET:      state_d = (cnt == CW'(RST_HOLD - 1)) ? WAIT_LOCK : RESET;
      WAIT_LOCK:  state_d = lock_hit ? LOCKED : tmo_hit ? FAIL : WAIT_LOCK;
`ifdef PLL_RELOCK_EN
      LOCKED:     state_d = start ? SHIFT : loss_hit ? RESET : LOCKED;
`else
      LOCKED:     state_d = start ? SHIFT : loss_hit ? FAIL : LOCKED;
`endif
      default:    state_d = IDLE;
    endcase
    cnt_d  = (state_d != state || (state == SHIFT && bit_end)) ? '0 : cnt + CW'(1);
    idx_d  = accept ? IW'(CFG_W - 1) : (state == SHIFT && bit_end) ? idx - IW'(1) : idx;
    filt_d = (state_d != state) ? '0 :
             ((state == WAIT_LOCK && lock_s) || (state == LOCKED && !lock_s)) ? filt + FW'(1) : '0;
    tcnt_d = (state_d != state || state != WAIT_LOCK) ? '0 : tcnt + TW'(1);
    tmo_d  = accept ? 1'b0 : (state == WAIT_LOCK && state_d == FAIL) ? 1'b1 : tmo_q;
    loss_d = (state == LOCKED && !start && loss_hit && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
  end

  always_comb begin
    busy_d    = state == SHIFT || state == LATCH || state == RESET || state == WAIT_LOCK;
    locked_d  = state == LOCKED;
    bypass_d  = state != LOCKED;
    reset_n_d = state == WAIT_LOCK || state == LOCKED;
    sclk_d    = state == SHIFT && cnt >= CW'(SCLK_DIV);
    sdi_d     = state == SHIFT && cfg_q[idx];
    latch_d   = state == LATCH;
  end

  // every port is a flop; sticky flags follow the same one-cycle pipeline as the FSM outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_n  <= 1'b0;
      pll_bypass   <= 1'b1;
      pll_sclk     <= 1'b0;
      pll_sdi      <= 1'b0;
      pll_latch    <= 1'b0;
      pll_dyndelay <= '0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      timeout_err  <= 1'b0;
      loss_cnt     <= '0;
    end else begin
      pll_reset_n  <= reset_n_d;
      pll_bypass   <= bypass_d;
      pll_sclk     <= sclk_d;
      pll_sdi      <= sdi_d;
      pll_latch    <= latch_d;
      pll_dyndelay <= dly_q;
      busy         <= busy_d;
      locked       <= locked_d;
      timeout_err  <= tmo_q;
      loss_cnt     <= loss_q;
    end
  end
endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// tb_pll_cfg_sequencer: scoreboard bench; stimulus queues expected PLL port events, a monitor pops and compares them.
module tb_pll_cfg_sequencer;
  localparam int CFG_W = 4, SCLK_DIV = 2, RST_HOLD = 4, LOCK_TIMEOUT = 100, LOCK_FILTER = 3;
  localparam int EV_LOSS = 0, EV_START = 1, EV_BIT = 2, EV_LATCH = 3, EV_RST = 4, EV_LOCK = 5, EV_TMO = 6;

  typedef struct { int k; int v; } ev_t;

  ev_t   exp_q[$];
  string kn[7] = '{"loss", "start", "sdi_bit", "latch_len", "rst_hold", "lock_latency", "timeout_latency"};
  int    tests, fails, model_loss, last_dly;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, pll_lock = 1'b0;
  logic [CFG_W-1:0] cfg_word = '0;
  logic [7:0]       dly_in = '0;
  logic             pll_reset_n, pll_bypass, pll_sclk, pll_sdi, pll_latch, busy, locked, timeout_err;
  logic [7:0]       pll_dyndelay, loss_cnt;

  pll_cfg_sequencer #(
    .CFG_W(CFG_W), .SCLK_DIV(SCLK_DIV), .RST_HOLD(RST_HOLD),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_FILTER(LOCK_FILTER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_word(cfg_word), .dly_in(dly_in),
    .pll_lock(pll_lock), .pll_reset_n(pll_reset_n), .pll_bypass(pll_bypass),
    .pll_sclk(pll_sclk), .pll_sdi(pll_sdi), .pll_latch(pll_latch),
    .pll_dyndelay(pll_dyndelay), .busy(busy), .locked(locked),
    .timeout_err(timeout_err), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void expect_ev(input int k, input int v);
    ev_t e;
    e.k = k;
    e.v = v;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int k, input int v);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s event: got %0d, nothing expected", kn[k], v);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v != v) begin
        fails++;
        $display("FAIL %s event: got %s=%0d, expected %s=%0d", kn[e.k], kn[k], v, kn[e.k], e.v);
      end
    end
  endtask

  // monitor: turns port activity into events with cycle-accurate lengths and latencies
  logic p_busy, p_sclk, p_latch, p_rn, p_locked, p_tmo;
  logic [7:0] p_loss;
  int latch_len, since_ref, since_rel;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        latch_len = 0;
        since_ref = 0;
        since_rel = 0;
      end else begin
        since_ref = ((p_latch && !pll_latch) || (p_locked && !locked)) ? 0 : since_ref + 1;
        since_rel = (pll_reset_n && !p_rn) ? 0 : since_rel + 1;
        latch_len = (pll_latch && !p_latch) ? 1 : pll_latch ? latch_len + 1 : latch_len;
        if (loss_cnt != p_loss)      got(EV_LOSS, int'(loss_cnt));
        if (busy && !p_busy)         got(EV_START, int'(pll_dyndelay));
        if (pll_sclk && !p_sclk)     got(EV_BIT, int'(pll_sdi));
        if (!pll_latch && p_latch)   got(EV_LATCH, latch_len);
        if (pll_reset_n && !p_rn)    got(EV_RST, since_ref);
        if (locked && !p_locked)     got(EV_LOCK, since_rel);
        if (timeout_err && !p_tmo)   got(EV_TMO, since_rel);
      end
      p_busy = busy; p_sclk = pll_sclk; p_latch = pll_latch; p_rn = pll_reset_n;
      p_locked = locked; p_tmo = timeout_err; p_loss = loss_cnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d events still pending after %0d cycles, next %s=%0d",
               name, exp_q.size(), budget, kn[exp_q[0].k], exp_q[0].v);
      exp_q.delete();
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, " pll_reset_n"}, pll_reset_n, 0);
    check({tag, " pll_bypass"}, pll_bypass, 1);
    check({tag, " pll_sclk"}, pll_sclk, 0);
    check({tag, " pll_sdi"}, pll_sdi, 0);
    check({tag, " pll_latch"}, pll_latch, 0);
    check({tag, " pll_dyndelay"}, pll_dyndelay, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " loss_cnt"}, loss_cnt, 0);
  endtask

  task automatic push_seq(input logic [CFG_W-1:0] cfg, input logic [7:0] dly, input bit lock_ok);
    expect_ev(EV_START, int'(dly));
    for (int i = CFG_W - 1; i >= 0; i--) expect_ev(EV_BIT, int'(cfg[i]));
    expect_ev(EV_LATCH, SCLK_DIV);
    expect_ev(EV_RST, RST_HOLD);
    if (lock_ok) expect_ev(EV_LOCK, LOCK_FILTER);
    else         expect_ev(EV_TMO, LOCK_TIMEOUT);
    last_dly = int'(dly);
  endtask

  task automatic pulse_start(input logic [CFG_W-1:0] cfg, input logic [7:0] dly);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_word = cfg;
    dly_in = dly;
    tick(1);
    start = 1'b0;
  endtask

  // spam > 0 fires a second start with different data that must be ignored
  task automatic run_seq(input logic [CFG_W-1:0] cfg, input logic [7:0] dly, input bit lock_ok, input int spam);
    push_seq(cfg, dly, lock_ok);
    pulse_start(cfg, dly);
    if (spam > 0) begin
      tick(spam - 1);
      pulse_start(~cfg, ~dly);
    end
    wait_drain(400, "sequence");
  endtask

  task automatic drop_lock(input int n);
    @(posedge clk);
    #1 pll_lock = 1'b0;
    tick(n);
    pll_lock = 1'b1;
  endtask

  task automatic expect_loss();
    if (model_loss < 255) begin
      model_loss++;
      expect_ev(EV_LOSS, model_loss);
    end
`ifdef PLL_RELOCK_EN
    expect_ev(EV_START, last_dly);
    expect_ev(EV_RST, RST_HOLD);
    expect_ev(EV_LOCK, LOCK_FILTER);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CFG_W-1:0] c;
    logic [7:0] d;
    tests = 0; fails = 0; model_loss = 0; last_dly = 0;
    tick(3);
    check_rst("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(50);
    check_rst("idle50");
    pll_lock = 1'b1;
    tick(5);
    run_seq(4'b1011, 8'h5A, 1'b1, 0);
    check("locked after seq", locked, 1);
    check("bypass after seq", pll_bypass, 0);
    check("dyndelay after seq", pll_dyndelay, 8'h5A);
    check("busy after seq", busy, 0);
    repeat (8) run_seq(CFG_W'($urandom), 8'($urandom), 1'b1, $urandom_range(2, 18));
    pll_lock = 1'b0;
    run_seq(CFG_W'($urandom), 8'($urandom), 1'b0, 60);
    tick(2);
    check("fail timeout_err", timeout_err, 1);
    check("fail pll_reset_n", pll_reset_n, 0);
    check("fail busy", busy, 0);
    check("fail locked", locked, 0);
    check("fail bypass", pll_bypass, 1);
    pll_lock = 1'b1;
    run_seq(CFG_W'($urandom), 8'($urandom), 1'b1, 0);
    check("restart clears timeout_err", timeout_err, 0);
    check("restart locked", locked, 1);
    drop_lock(2);
    tick(10);
    check("glitch loss_cnt", loss_cnt, model_loss);
    check("glitch locked", locked, 1);
    expect_loss();
    drop_lock(5);
    wait_drain(100, "lock loss");
    tick(3);
    check("loss loss_cnt", loss_cnt, 1);
    check("loss timeout_err", timeout_err, 0);
`ifdef PLL_RELOCK_EN
    check("relock locked", locked, 1);
    check("relock bypass", pll_bypass, 0);
    repeat (300) begin
      expect_loss();
      drop_lock(5);
      wait_drain(100, "relock loss");
    end
    tick(2);
    check("loss_cnt saturated", loss_cnt, 255);
    check("relock after saturation", locked, 1);
`else
    check("loss locked", locked, 0);
    check("loss bypass", pll_bypass, 1);
    check("loss pll_reset_n", pll_reset_n, 0);
    check("loss busy", busy, 0);
    tick(20);
    check("loss stays in fail", locked, 0);
    run_seq(CFG_W'($urandom), 8'($urandom), 1'b1, 0);
    check("recover locked", locked, 1);
    check("recover loss_cnt kept", loss_cnt, 1);
`endif
    c = CFG_W'($urandom);
    d = 8'($urandom_range(1, 255));
    push_seq(c, d, 1'b1);
    pulse_start(c, d);
    tick(3);
    check("mid-shift sclk high", pll_sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check_rst("mid_shift_reset");
    exp_q.delete();
    model_loss = 0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    run_seq(CFG_W'($urandom), 8'($urandom), 1'b1, $urandom_range(2, 18));
    check("post-reset locked", locked, 1);
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
